// File: rtl/gray_pkg.sv
// Shared definitions for the Gray decoder: FSM state encoding and a generic
// Gray-to-binary conversion function usable at any width up to GRAY_MAX_W.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  typedef enum logic [1:0] {
    UNLOCKED = ST_UNLOCKED,
    LOCKED   = ST_LOCKED,
    FAULT    = ST_FAULT
  } state_t;

  // Zero-extended Gray input converts to a zero-extended binary result,
  // so narrower codes can be converted by casting in and out.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterised combinational Gray-to-binary converter.
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_decoder.sv
// Gray-code receiver: converts samples to binary, tracks single steps,
// counts net position and flags wraps and illegal multi-bit jumps.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int POS_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] Gray_in,
  input  logic             Clear,
  output logic [WIDTH-1:0] Bin_out,
  output logic             Locked,
  output logic             Step_up,
  output logic             Step_down,
  output logic [POS_W-1:0] Position,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Error
);

  state_t           state;
  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] diff;
  logic [POS_W-1:0] pos_base;

  gray2bin #(.WIDTH(WIDTH)) u_conv (
    .gray (Gray_in),
    .bin  (b_new)
  );

  assign diff = b_new - Bin_out;

  // Clear applies before a same-cycle sample, so steps count from zero.
  assign pos_base = Clear ? '0 : Position;

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the block deliberately override the Clear defaults.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= UNLOCKED;
      Bin_out   <= '0;
      Locked    <= 1'b0;
      Step_up   <= 1'b0;
      Step_down <= 1'b0;
      Position  <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Step_up   <= 1'b0;
      Step_down <= 1'b0;
      if (Clear) begin
        Position  <= '0;
        Overflow  <= 1'b0;
        Underflow <= 1'b0;
        Error     <= 1'b0;
      end
      if (In_valid) begin
        case (state)
          LOCKED: begin
            if (diff == WIDTH'(1)) begin
              Bin_out  <= b_new;
              Step_up  <= 1'b1;
              Position <= pos_base + POS_W'(1);
              if (Bin_out == '1) Overflow <= 1'b1;
            end else if (diff == '1) begin
              Bin_out   <= b_new;
              Step_down <= 1'b1;
              Position  <= pos_base - POS_W'(1);
              if (Bin_out == '0) Underflow <= 1'b1;
            end else if (diff != '0) begin
              Error  <= 1'b1;
              state  <= FAULT;
              Locked <= 1'b0;
            end
          end
          default: begin
            Bin_out <= b_new;
            state   <= LOCKED;
            Locked  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder (WIDTH=3, POS_W=8).
module tb_gray_decoder;

  localparam int WIDTH = 3;
  localparam int POS_W = 8;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             In_valid = 1'b0;
  logic [WIDTH-1:0] Gray_in = '0;
  logic             Clear = 1'b0;
  logic [WIDTH-1:0] Bin_out;
  logic             Locked, Step_up, Step_down, Overflow, Underflow, Error;
  logic [POS_W-1:0] Position;

  int n_tests = 0;
  int n_fail  = 0;

  // {Bin_out, Locked, Step_up, Step_down, Position, Overflow, Underflow, Error}
  logic [16:0] obs;
  logic [16:0] exp_v;
  assign obs = {Bin_out, Locked, Step_up, Step_down, Position, Overflow, Underflow, Error};

  gray_decoder #(.WIDTH(WIDTH), .POS_W(POS_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In_valid  (In_valid),
    .Gray_in   (Gray_in),
    .Clear     (Clear),
    .Bin_out   (Bin_out),
    .Locked    (Locked),
    .Step_up   (Step_up),
    .Step_down (Step_down),
    .Position  (Position),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of stimulus, then settle just after the sampling edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] g, input logic clr);
    @(negedge Clk);
    In_valid = v;
    Gray_in  = g;
    Clear    = clr;
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
    Clear    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n  = 1'b0;
    In_valid = 1'b0;
    Clear    = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", obs, 17'd0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_up_run();
    logic [WIDTH-1:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                  3'b111, 3'b101, 3'b100, 3'b000};
    do_reset();
    drive(1'b1, seq[0], 1'b0);
    exp_v = {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL up_lock got %h exp %h", obs, exp_v);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, seq[i], 1'b0);
      exp_v = {3'(i % 8), 1'b1, 1'b1, 1'b0, 8'(i), (i == 8), 1'b0, 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL up_step%0d got %h exp %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b100, 1'b0);
    exp_v = {3'd7, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL down_wrap got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_error_relock();
    do_reset();
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b011, 1'b0);
    exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL err_jump got %h exp %h", obs, exp_v);
    end
    drive(1'b1, 3'b010, 1'b0);
    exp_v = {3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL err_relock got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_hold_and_gaps();
    do_reset();
    drive(1'b1, 3'b001, 1'b0);
    drive(1'b0, 3'b011, 1'b0);
    drive(1'b1, 3'b001, 1'b0);
    drive(1'b0, 3'b111, 1'b0);
    exp_v = {3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL hold_gap got %h exp %h", obs, exp_v);
    end
    drive(1'b1, 3'b001, 1'b0);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL hold_same got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_clear();
    logic [WIDTH-1:0] seq [5] = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    do_reset();
    drive(1'b1, 3'b110, 1'b0);
    foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
    exp_v = {3'd1, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_setup got %h exp %h", obs, exp_v);
    end
    drive(1'b1, 3'b011, 1'b1);
    exp_v = {3'd2, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_with_step got %h exp %h", obs, exp_v);
    end
    drive(1'b1, 3'b110, 1'b1);
    exp_v = {3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_with_error got %h exp %h", obs, exp_v);
    end
    drive(1'b0, 3'b000, 1'b1);
    exp_v = {3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_alone got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b001, 1'b0);
    exp_v = {3'd1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL async_pre got %h exp %h", obs, exp_v);
    end
    #1;
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL async_mid got %h exp %h", obs, 17'd0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(1'b1, 3'b011, 1'b0);
    exp_v = {3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL async_relock got %h exp %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_up_run();
    test_down_wrap();
    test_error_relock();
    test_hold_and_gaps();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
